flag_flush_ctrl: RTL and testbench
==================================

# flag_flush_ctrl

Collects result flags from all execution ports and finds the oldest in-flight instruction that needs a pipeline flush or a trap. It holds that event until the instruction reaches the head of the reorder buffer. It then sequences the flush: a one-cycle flush pulse, followed by a commit stall until the backend reports the drain is complete. It sits between the execution result buses and the commit stage.

## Interface
- NUM_PORTS, 4, number of execution result ports
- SQN_W, 7, sequence-number width; ROB age space is 2^SQN_W, modular
- PC_W, 32, program counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IN_res_valid  in  NUM_PORTS  per-port result valid
- IN_res_flags  in  4*NUM_PORTS  per-port flag code; port i at bits [4i+3:4i]
- IN_res_sqN  in  SQN_W*NUM_PORTS  per-port sequence number
- IN_res_pc  in  PC_W*NUM_PORTS  per-port instruction PC
- IN_commitSqN  in  SQN_W  sequence number of the current ROB head (oldest uncommitted)
- IN_squash_valid  in  1  mispredict squash from the branch unit
- IN_squash_sqN  in  SQN_W  squash point; everything strictly younger is killed
- IN_drainDone  in  1  backend has finished flushing
- OUT_flush  out  1  flush pulse
- OUT_flushSqN  out  SQN_W  sequence number of the flushing instruction
- OUT_flushFlags  out  4  flag code of the flushing instruction
- OUT_flushPC  out  PC_W  PC of the flushing instruction
- OUT_isTrap  out  1  the flush is a trap (flag code 6..14)
- OUT_stallCommit  out  1  commit must not retire

## Operation
- Flag codes:
  - NONE=0, BRANCH=1, PRED_TAKEN=2, PRED_NTAKEN=3
  - FENCE=4, ORDERING=5, ILLEGAL_INSTR=6, TRAP=7
  - LD_MA=8, LD_AF=9, LD_PF=10, ST_MA=11, ST_AF=12, ST_PF=13
  - XRET=14, NX=15
- Event classes:
  - A port carries an event if it is valid and its flag code is 4..14.
  - Codes 4..5 are the flush class; codes 6..14 are the trap class.
  - Codes 0..3 and 15 are ignored.
- Age: age(x) = (x - IN_commitSqN) mod 2^SQN_W, computed in SQN_W bits. A smaller age is older.
- Arbitration: among the eligible ports, the smallest age wins. On equal age, the lowest port index wins.
- States:
  - IDLE: a winning event is registered into pend_{sqN,flags,pc}; next state is PENDING.
  - PENDING:
    - An incoming winner strictly older than pend replaces pend. An equal-age winner does not replace it.
    - If pend_sqN == IN_commitSqN, next state is FLUSH.
  - FLUSH: lasts exactly one cycle; next state is DRAIN.
  - DRAIN: when IN_drainDone=1, next state is IDLE.
- Squash (honoured in IDLE and PENDING only):
  - An incoming event with age > age(IN_squash_sqN) is dropped.
  - In PENDING, if age(pend_sqN) > age(IN_squash_sqN), next state is IDLE and pend is discarded. This takes priority over the commit match.
  - A squash and a surviving older event in the same cycle: squash first, then capture.
- Events arriving in FLUSH or DRAIN are ignored, since those instructions are being flushed.
- Outputs:
  - OUT_flush=1 only in FLUSH.
  - OUT_flushSqN, OUT_flushFlags and OUT_flushPC show pend and are valid when OUT_flush=1.
  - OUT_isTrap = (pend_flags >= 6) and (pend_flags <= 14), qualified by OUT_flush.
  - OUT_stallCommit=1 in PENDING when pend_sqN == IN_commitSqN, and in FLUSH and DRAIN. This keeps the head from retiring before the flush.
- Reset: state IDLE, pend cleared, every output 0. Deasserting rst_n mid-operation abandons any pending or in-progress flush.

## Timing
- All state and outputs are registered; the combinational path is limited to arbitration and the OUT_stallCommit head compare.
- Event at cycle t in IDLE: pend is valid at t+1.
  - If pend_sqN equals the head at t+1: OUT_flush=1 at t+2. Minimum event-to-flush latency is 2 cycles.
- IN_drainDone sampled high at cycle d in DRAIN: IDLE at d+1, and a new capture is possible at d+1.
- IN_drainDone is ignored outside DRAIN.
- Modular age is correct across sqN wrap, for example head=126 and sqN=1 gives age 3.

## Test plan
- Single event: port 2 sends ORDERING(5) with sqN=10, head=10.
  - Required: OUT_flush exactly 2 cycles later, with flushSqN=10, flags=5, isTrap=0.
  - Then hold IN_drainDone=0 for 5 cycles: stallCommit stays high and the block returns to IDLE after drainDone.
- Oldest wins with wrap: head=126; port 0 sends LD_PF(10) with sqN=3, port 3 sends ILLEGAL_INSTR(6) with sqN=127 in the same cycle.
  - Required: pend sqN=127.
  - Step head to 127: flush with flags=6 and isTrap=1.
- Replacement and tie:
  - While pending sqN=20 (head=15), an event with sqN=17 replaces it.
  - Then two ports with sqN=17 and different flags: the lower port's flags are kept, and pend is unchanged.
- Squash: pending sqN=30, head=25; IN_squash_sqN=28.
  - Required: next cycle IDLE, no OUT_flush.
  - Repeat with squash_sqN=32: pend is kept.
- Ignored codes and states:
  - Flags 0, 1, 2, 3 and 15 never set pend.
  - A FENCE arriving during DRAIN is not flushed afterwards.
- Reset mid-flush: assert rst_n=0 in DRAIN.
  - Required: all outputs 0 immediately, and the block is in IDLE after release.

Source files
------------

// File: rtl/flag_flush_ctrl_if.sv
// rtl/flag_flush_ctrl_if.sv - execution result bus carrying per-port flags into the flush controller
interface flag_flush_ctrl_if #(
   parameter int NUM_PORTS = 4,
   parameter int SQN_W     = 7,
   parameter int PC_W      = 32
);
   logic [NUM_PORTS-1:0]       IN_res_valid;
   logic [4*NUM_PORTS-1:0]     IN_res_flags;
   logic [SQN_W*NUM_PORTS-1:0] IN_res_sqN;
   logic [PC_W*NUM_PORTS-1:0]  IN_res_pc;

   modport master (
      output IN_res_valid,
      output IN_res_flags,
      output IN_res_sqN,
      output IN_res_pc
   );

   modport slave (
      input IN_res_valid,
      input IN_res_flags,
      input IN_res_sqN,
      input IN_res_pc
   );
endinterface

// File: rtl/flag_flush_ctrl.sv
// rtl/flag_flush_ctrl.sv - picks the oldest flush/trap event and sequences flush pulse plus commit stall
module flag_flush_ctrl #(
   parameter int NUM_PORTS = 4,
   parameter int SQN_W     = 7,
   parameter int PC_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   flag_flush_ctrl_if.slave     res,
   input  logic [SQN_W-1:0]     IN_commitSqN,
   input  logic                 IN_squash_valid,
   input  logic [SQN_W-1:0]     IN_squash_sqN,
   input  logic                 IN_drainDone,
   output logic                 OUT_flush,
   output logic [SQN_W-1:0]     OUT_flushSqN,
   output logic [3:0]           OUT_flushFlags,
   output logic [PC_W-1:0]      OUT_flushPC,
   output logic                 OUT_isTrap,
   output logic                 OUT_stallCommit
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PENDING = 2'd1;
   localparam logic [1:0] S_FLUSH   = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SQN_W-1:0] pend_sqn_q, pend_sqn_d;
   logic [3:0]       pend_flags_q, pend_flags_d;
   logic [PC_W-1:0]  pend_pc_q, pend_pc_d;

   logic             win_valid;
   logic [SQN_W-1:0] win_age, win_sqn;
   logic [3:0]       win_flags;
   logic [PC_W-1:0]  win_pc;
   logic [SQN_W-1:0] squash_age, pend_age;
   logic [SQN_W-1:0] p_sqn, p_age;
   logic [3:0]       p_flags;
   logic             p_ok;
   logic             pend_killed;

   // Ages are modular distances from the ROB head; a strict compare keeps the lowest port on ties.
   always_comb begin
      win_valid  = 1'b0;
      win_age    = '0;
      win_sqn    = '0;
      win_flags  = '0;
      win_pc     = '0;
      p_sqn      = '0;
      p_age      = '0;
      p_flags    = '0;
      p_ok       = 1'b0;
      squash_age = IN_squash_sqN - IN_commitSqN;
      for (int i = 0; i < NUM_PORTS; i++) begin
         p_flags = res.IN_res_flags[4*i +: 4];
         p_sqn   = res.IN_res_sqN[SQN_W*i +: SQN_W];
         p_age   = p_sqn - IN_commitSqN;
         p_ok    = res.IN_res_valid[i] && (p_flags >= 4'd4) && (p_flags <= 4'd14)
                   && !(IN_squash_valid && (p_age > squash_age));
         if (p_ok && (!win_valid || (p_age < win_age))) begin
            win_valid = 1'b1;
            win_age   = p_age;
            win_sqn   = p_sqn;
            win_flags = p_flags;
            win_pc    = res.IN_res_pc[PC_W*i +: PC_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_sqn_d   = pend_sqn_q;
      pend_flags_d = pend_flags_q;
      pend_pc_d    = pend_pc_q;
      pend_age     = pend_sqn_q - IN_commitSqN;
      pend_killed  = IN_squash_valid && (pend_age > squash_age);
      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               state_d      = S_PENDING;
               pend_sqn_d   = win_sqn;
               pend_flags_d = win_flags;
               pend_pc_d    = win_pc;
            end
         end
         S_PENDING: begin
            // A killed pend frees the slot for any surviving event in the same cycle.
            if (pend_killed) begin
               state_d = S_IDLE;
               if (win_valid) begin
                  state_d      = S_PENDING;
                  pend_sqn_d   = win_sqn;
                  pend_flags_d = win_flags;
                  pend_pc_d    = win_pc;
               end
            end else if (pend_sqn_q == IN_commitSqN) begin
               state_d = S_FLUSH;
            end else if (win_valid && (win_age < pend_age)) begin
               pend_sqn_d   = win_sqn;
               pend_flags_d = win_flags;
               pend_pc_d    = win_pc;
            end
         end
         S_FLUSH: state_d = S_DRAIN;
         S_DRAIN: begin
            if (IN_drainDone) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pend_sqn_q   <= '0;
         pend_flags_q <= '0;
         pend_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pend_sqn_q   <= pend_sqn_d;
         pend_flags_q <= pend_flags_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign OUT_flush       = (state_q == S_FLUSH);
   assign OUT_flushSqN    = pend_sqn_q;
   assign OUT_flushFlags  = pend_flags_q;
   assign OUT_flushPC     = pend_pc_q;
   assign OUT_isTrap      = OUT_flush && (pend_flags_q >= 4'd6) && (pend_flags_q <= 4'd14);
   assign OUT_stallCommit = ((state_q == S_PENDING) && (pend_sqn_q == IN_commitSqN))
                            || (state_q == S_FLUSH) || (state_q == S_DRAIN);
endmodule

// File: tb/tb_flag_flush_ctrl.sv
// tb/tb_flag_flush_ctrl.sv - directed self-checking bench for flag_flush_ctrl
module tb_flag_flush_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  commit_sqn;
   logic        squash_valid;
   logic [6:0]  squash_sqn;
   logic        drain_done;
   logic        flush;
   logic [6:0]  flush_sqn;
   logic [3:0]  flush_flags;
   logic [31:0] flush_pc;
   logic        is_trap;
   logic        stall;
   int          total = 0;
   int          bad = 0;

   flag_flush_ctrl_if #(.NUM_PORTS(4), .SQN_W(7), .PC_W(32)) res_if ();

   flag_flush_ctrl #(.NUM_PORTS(4), .SQN_W(7), .PC_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .res             (res_if.slave),
      .IN_commitSqN    (commit_sqn),
      .IN_squash_valid (squash_valid),
      .IN_squash_sqN   (squash_sqn),
      .IN_drainDone    (drain_done),
      .OUT_flush       (flush),
      .OUT_flushSqN    (flush_sqn),
      .OUT_flushFlags  (flush_flags),
      .OUT_flushPC     (flush_pc),
      .OUT_isTrap      (is_trap),
      .OUT_stallCommit (stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ports();
      res_if.IN_res_valid = '0;
      res_if.IN_res_flags = '0;
      res_if.IN_res_sqN   = '0;
      res_if.IN_res_pc    = '0;
   endtask

   task automatic set_port(input int p, input logic [3:0] f, input logic [6:0] s, input logic [31:0] pc);
      res_if.IN_res_valid[p]       = 1'b1;
      res_if.IN_res_flags[4*p +: 4] = f;
      res_if.IN_res_sqN[7*p +: 7]  = s;
      res_if.IN_res_pc[32*p +: 32] = pc;
   endtask

   // Called right after the FLUSH cycle is observed: one edge into DRAIN, one edge out.
   task automatic drain_out();
      drain_done = 1'b1;
      tick();
      tick();
      drain_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      commit_sqn = '0;
      squash_valid = 1'b0;
      squash_sqn = '0;
      drain_done = 1'b0;
      clear_ports();
      #3;
      total++; if ({flush, is_trap, stall, flush_flags, flush_sqn, flush_pc} !== '0) begin bad++; $display("FAIL reset_outputs got flush=%0b trap=%0b stall=%0b sqn=%0d required all zero", flush, is_trap, stall, flush_sqn); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_idle_stall got=%0b required=0", stall); end
   endtask

   task automatic test_single();
      commit_sqn = 7'd10;
      set_port(2, 4'd5, 7'd10, 32'h0000_1000);
      tick();
      clear_ports();
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL single_pend_stall got=%0b required=1", stall); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL single_early_flush got=%0b required=0", flush); end
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL single_flush got=%0b required=1", flush); end
      total++; if (flush_sqn !== 7'd10) begin bad++; $display("FAIL single_sqn got=%0d required=10", flush_sqn); end
      total++; if (flush_flags !== 4'd5) begin bad++; $display("FAIL single_flags got=%0d required=5", flush_flags); end
      total++; if (flush_pc !== 32'h0000_1000) begin bad++; $display("FAIL single_pc got=%0h required=1000", flush_pc); end
      total++; if (is_trap !== 1'b0) begin bad++; $display("FAIL single_trap got=%0b required=0", is_trap); end
      drain_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++; if ({flush, stall} !== 2'b01) begin bad++; $display("FAIL single_drain_hold cycle %0d got flush=%0b stall=%0b required flush=0 stall=1", k, flush, stall); end
      end
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      total++; if ({flush, stall} !== 2'b00) begin bad++; $display("FAIL single_back_idle got flush=%0b stall=%0b required 0 0", flush, stall); end
   endtask

   task automatic test_wrap();
      commit_sqn = 7'd126;
      set_port(0, 4'd10, 7'd3, 32'h0000_3000);
      set_port(3, 4'd6, 7'd127, 32'h0000_2000);
      tick();
      clear_ports();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL wrap_no_stall_at_126 got=%0b required=0", stall); end
      commit_sqn = 7'd127;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL wrap_pend_127 got stall=%0b required=1", stall); end
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL wrap_flush got=%0b required=1", flush); end
      total++; if (flush_sqn !== 7'd127) begin bad++; $display("FAIL wrap_sqn got=%0d required=127", flush_sqn); end
      total++; if (flush_flags !== 4'd6) begin bad++; $display("FAIL wrap_flags got=%0d required=6", flush_flags); end
      total++; if (is_trap !== 1'b1) begin bad++; $display("FAIL wrap_trap got=%0b required=1", is_trap); end
      total++; if (flush_pc !== 32'h0000_2000) begin bad++; $display("FAIL wrap_pc got=%0h required=2000", flush_pc); end
      drain_out();
   endtask

   task automatic test_replace_tie();
      commit_sqn = 7'd15;
      set_port(1, 4'd5, 7'd20, 32'h0000_A000);
      tick();
      clear_ports();
      commit_sqn = 7'd20;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL replace_initial_pend got stall=%0b required=1", stall); end
      commit_sqn = 7'd15;
      set_port(0, 4'd8, 7'd17, 32'h0000_B000);
      tick();
      clear_ports();
      commit_sqn = 7'd20;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL replace_old_gone got stall=%0b required=0", stall); end
      commit_sqn = 7'd15;
      set_port(1, 4'd11, 7'd17, 32'h0000_C000);
      set_port(2, 4'd12, 7'd17, 32'h0000_D000);
      tick();
      clear_ports();
      commit_sqn = 7'd17;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL replace_pend_17 got stall=%0b required=1", stall); end
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL replace_flush got=%0b required=1", flush); end
      total++; if (flush_flags !== 4'd8) begin bad++; $display("FAIL tie_keeps_pend_flags got=%0d required=8", flush_flags); end
      total++; if (flush_pc !== 32'h0000_B000) begin bad++; $display("FAIL tie_keeps_pend_pc got=%0h required=b000", flush_pc); end
      total++; if (is_trap !== 1'b1) begin bad++; $display("FAIL replace_trap got=%0b required=1", is_trap); end
      drain_out();
   endtask

   task automatic test_tie_idle();
      commit_sqn = 7'd40;
      set_port(3, 4'd7, 7'd41, 32'h0000_E000);
      set_port(1, 4'd9, 7'd41, 32'h0000_F000);
      tick();
      clear_ports();
      commit_sqn = 7'd41;
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL tie_idle_flush got=%0b required=1", flush); end
      total++; if (flush_flags !== 4'd9) begin bad++; $display("FAIL tie_idle_low_port_flags got=%0d required=9", flush_flags); end
      total++; if (flush_pc !== 32'h0000_F000) begin bad++; $display("FAIL tie_idle_low_port_pc got=%0h required=f000", flush_pc); end
      drain_out();
   endtask

   task automatic test_squash();
      commit_sqn = 7'd25;
      set_port(0, 4'd5, 7'd30, 32'h0000_0300);
      tick();
      clear_ports();
      squash_valid = 1'b1;
      squash_sqn = 7'd28;
      tick();
      squash_valid = 1'b0;
      commit_sqn = 7'd30;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL squash_to_idle got stall=%0b required=0", stall); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL squash_no_flush got=%0b required=0", flush); end
      commit_sqn = 7'd25;
      set_port(0, 4'd5, 7'd30, 32'h0000_0300);
      tick();
      clear_ports();
      squash_valid = 1'b1;
      squash_sqn = 7'd32;
      tick();
      squash_valid = 1'b0;
      commit_sqn = 7'd30;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL squash_keep_pend got stall=%0b required=1", stall); end
      tick();
      total++; if ({flush, flush_sqn} !== {1'b1, 7'd30}) begin bad++; $display("FAIL squash_keep_flush got flush=%0b sqn=%0d required 1 30", flush, flush_sqn); end
      drain_out();
      commit_sqn = 7'd25;
      set_port(0, 4'd5, 7'd30, 32'h0000_0300);
      tick();
      clear_ports();
      squash_valid = 1'b1;
      squash_sqn = 7'd28;
      set_port(1, 4'd4, 7'd29, 32'h0000_0290);
      set_port(2, 4'd4, 7'd27, 32'h0000_0270);
      tick();
      clear_ports();
      squash_valid = 1'b0;
      commit_sqn = 7'd27;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL squash_then_capture got stall=%0b required=1", stall); end
      tick();
      total++; if ({flush, flush_sqn, flush_flags} !== {1'b1, 7'd27, 4'd4}) begin bad++; $display("FAIL squash_capture_flush got flush=%0b sqn=%0d flags=%0d required 1 27 4", flush, flush_sqn, flush_flags); end
      total++; if (flush_pc !== 32'h0000_0270) begin bad++; $display("FAIL squash_capture_pc got=%0h required=270", flush_pc); end
      drain_out();
   endtask

   task automatic test_ignored();
      logic [3:0] codes [5];
      codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
      commit_sqn = 7'd50;
      for (int k = 0; k < 5; k++) begin
         set_port(0, codes[k], 7'd50, 32'h0000_0500);
         tick();
         clear_ports();
         total++; if (stall !== 1'b0) begin bad++; $display("FAIL ignored_code_%0d got stall=%0b required=0", codes[k], stall); end
         tick();
         total++; if (flush !== 1'b0) begin bad++; $display("FAIL ignored_code_%0d_flush got=%0b required=0", codes[k], flush); end
      end
      commit_sqn = 7'd60;
      set_port(1, 4'd5, 7'd60, 32'h0000_0600);
      tick();
      clear_ports();
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL drain_fence_setup got=%0b required=1", flush); end
      tick();
      set_port(0, 4'd4, 7'd61, 32'h0000_0610);
      tick();
      clear_ports();
      drain_done = 1'b1;
      tick();
      drain_done = 1'b0;
      commit_sqn = 7'd61;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL drain_fence_ignored got stall=%0b required=0", stall); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL drain_fence_no_flush got=%0b required=0", flush); end
   endtask

   task automatic test_back_to_back();
      commit_sqn = 7'd70;
      set_port(0, 4'd6, 7'd70, 32'h0000_0700);
      tick();
      clear_ports();
      tick();
      drain_done = 1'b1;
      tick();
      tick();
      drain_done = 1'b0;
      commit_sqn = 7'd71;
      set_port(2, 4'd13, 7'd71, 32'h0000_0710);
      tick();
      clear_ports();
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_capture got stall=%0b required=1", stall); end
      tick();
      total++; if ({flush, flush_flags, is_trap} !== {1'b1, 4'd13, 1'b1}) begin bad++; $display("FAIL b2b_flush got flush=%0b flags=%0d trap=%0b required 1 13 1", flush, flush_flags, is_trap); end
      drain_out();
   endtask

   task automatic test_reset_mid();
      commit_sqn = 7'd80;
      set_port(0, 4'd14, 7'd80, 32'h0000_0800);
      tick();
      clear_ports();
      tick();
      tick();
      total++; if ({flush, stall} !== 2'b01) begin bad++; $display("FAIL rstmid_in_drain got flush=%0b stall=%0b required 0 1", flush, stall); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({flush, is_trap, stall, flush_flags, flush_sqn, flush_pc} !== '0) begin bad++; $display("FAIL rstmid_outputs got flush=%0b trap=%0b stall=%0b flags=%0d sqn=%0d required all zero", flush, is_trap, stall, flush_flags, flush_sqn); end
      tick();
      rst_n = 1'b1;
      tick();
      total++; if ({flush, stall} !== 2'b00) begin bad++; $display("FAIL rstmid_idle got flush=%0b stall=%0b required 0 0", flush, stall); end
      set_port(1, 4'd7, 7'd80, 32'h0000_0810);
      tick();
      clear_ports();
      tick();
      total++; if ({flush, flush_flags} !== {1'b1, 4'd7}) begin bad++; $display("FAIL rstmid_recapture got flush=%0b flags=%0d required 1 7", flush, flush_flags); end
      drain_out();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_replace_tie();
      test_tie_idle();
      test_squash();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
